// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) receive types, FSM states and bit positions.
// Parity at e3,e1,e0; data at e6,e5,e4,e2.
package hamming_pkg;

  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syndrome_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 3;
  localparam int D0 = 2;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  function automatic data_t extract(
    input codeword_t c
  );
    return {c[D3], c[D2], c[D1], c[D0]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and single-bit fix.
// Ports: word in, syn out, fixed (corrected word) out.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  codeword_t word,
  output syndrome_t syn,
  output codeword_t fixed
);

  codeword_t flip;

  always_comb begin
    syn[2] = word[P2] ^ word[D3]
           ^ word[D2] ^ word[D1];
    syn[1] = word[P1] ^ word[D3]
           ^ word[D2] ^ word[D0];
    syn[0] = word[P0] ^ word[D3]
           ^ word[D1] ^ word[D0];
  end

  // Syndrome value s points at e[s-1].
  always_comb begin
    flip = '0;
    if (syn != 3'd0)
      flip = codeword_t'(1) << (syn - 3'd1);
  end

  assign fixed = word ^ flip;

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Hamming(7,4) receive controller: latch, decode, hold.
// Ports: in_valid/in_word/in_ready, out_* result, err_cnt (ERR_COUNT_EN).
module hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [6:0]           in_word,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_data,
  output logic [3:0]           out_syndrome,
  output logic                 out_corrected,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t    state_q;
  state_t    state_d;
  codeword_t word_q;
  codeword_t fixed;
  syndrome_t syn;
  syndrome_t syn_q;
  data_t     data_q;
  logic      corr_q;

  hamming_syndrome u_syn (
    .word  (word_q),
    .syn   (syn),
    .fixed (fixed)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      corr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid)
        word_q <= in_word;
      if (state_q == CALC) begin
        data_q <= extract(fixed);
        syn_q  <= syn;
        corr_q <= (syn != 3'd0);
      end
    end
  end

  assign out_data      = data_q;
  assign out_syndrome  = {1'b0, syn_q};
  assign out_corrected = corr_q;

`ifdef ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  // Counts on the CALC->DONE edge, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q == CALC
             && syn != 3'd0
             && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Scoreboard bench for hamming_rx_ctrl.
// Directed codewords; monitor checks results and latency.
module tb_hamming_rx_ctrl;

  localparam int W = 2;

  typedef struct {
    logic [3:0]   d;
    logic [3:0]   s;
    logic         c;
    logic [W-1:0] n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [6:0]   in_word = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   out_data;
  logic [3:0]   out_syndrome;
  logic         out_corrected;
  logic [W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_cnt = 0;
  exp_t exp_q[$];
  int acc_q[$];

  hamming_rx_ctrl #(.ERR_CNT_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_word       (in_word),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  // Monitor: results, latency, hold stability.
  logic       held = 1'b0;
  logic       pv = 1'b0;
  logic [3:0] hd;
  logic [3:0] hs;
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      held = 1'b0;
      pv = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(hd));
        chk("hold_syn", 32'(out_syndrome), 32'(hs));
        chk("hold_rdy", 32'(in_ready), 0);
      end
      if (out_valid && !pv) begin
        if (acc_q.size() == 0) begin
          chk("lat_noacc", 0, 1);
        end else begin
          chk("latency", 32'(cyc - acc_q.pop_front()), 2);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hdead);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e.d));
          chk("syn", 32'(out_syndrome), 32'(e.s));
          chk("corr", 32'(out_corrected), 32'(e.c));
          chk("err_cnt", 32'(err_cnt), 32'(e.n));
        end
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
      held = out_valid && !out_ready;
      hd = out_data;
      hs = out_syndrome;
      pv = out_valid;
    end
  end

  task automatic send(
    input logic [6:0] w,
    input logic [3:0] d,
    input logic [3:0] s
  );
    exp_t e;
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_word = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        e.d = d;
        e.s = s;
        e.c = (s != 4'h0);
`ifdef ERR_COUNT_EN
        if (e.c && model_cnt < (1 << W) - 1)
          model_cnt++;
`endif
        e.n = W'(model_cnt);
        exp_q.push_back(e);
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_cnt = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_syn", 32'(out_syndrome), 0);
    chk("rst_corr", 32'(out_corrected), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    #10;
    rst_n = 1'b1;

    send(7'h55, 4'b1011, 4'h0);
    send(7'h75, 4'b1011, 4'h6);
    send(7'h54, 4'b1011, 4'h1);
    send(7'h15, 4'b1011, 4'h7);
    send(7'h7F, 4'b1111, 4'h0);
    send(7'h00, 4'b0000, 4'h0);
    drain();

    // Backpressure with a second word waiting.
    out_ready = 1'b0;
    send(7'h5D, 4'b1011, 4'h4);
    fork
      send(7'h55, 4'b1011, 4'h0);
      begin
        for (int i = 0; i < 20 && !out_valid; i++)
          @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("bp_rdy", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while the word sits in CALC.
    @(posedge clk);
    #1;
    in_word = 7'h75;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rc_rdy", 32'(in_ready), 1);
    chk("rc_vld", 32'(out_valid), 0);
    chk("rc_data", 32'(out_data), 0);
    chk("rc_cnt", 32'(err_cnt), 0);
    model_cnt = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rc_noout", 32'(out_valid), 0);

    // Saturating counter with corrupted words.
    do_reset();
    send(7'h54, 4'b1011, 4'h1);
    send(7'h57, 4'b1011, 4'h2);
    send(7'h51, 4'b1011, 4'h3);
    send(7'h5D, 4'b1011, 4'h4);
    send(7'h45, 4'b1011, 4'h5);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming_rx_ctrl.md
HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating corrected-error counter.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a received 7-bit codeword is present on in_word.
REQ-005 in_word  input  7  Hamming(7,4) codeword e[6:0]; parity bits e[3], e[1], e[0]; data bits e[6], e[5], e[4], e[2].
REQ-006 in_ready  output  1  block can accept a codeword this cycle.
REQ-007 out_valid  output  1  decoded result is held on the out_* ports.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 out_data  output  4  corrected data {e6,e5,e4,e2}.
REQ-010 out_syndrome  output  4  {1'b0, s[2:0]}; bit 3 is constant 0 so the value drives the display decoder directly.
REQ-011 out_corrected  output  1  syndrome was non-zero and one bit was flipped.
REQ-012 err_cnt  output  ERR_CNT_W  number of corrected words since reset.

Function
REQ-013 Syndrome bit s2 SHALL be e3^e6^e5^e4.
REQ-014 Syndrome bit s1 SHALL be e1^e6^e5^e2.
REQ-015 Syndrome bit s0 SHALL be e0^e6^e4^e2.
REQ-016 A non-zero syndrome s SHALL identify bit e[s-1] as erroneous; that bit SHALL be inverted before data extraction; s=0 means no correction.
REQ-017 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-018 In IDLE, in_ready=1 and out_valid=0; in_valid=1 SHALL latch in_word into an internal register and move to CALC.
REQ-019 In CALC, in_ready=0; on the next edge the block SHALL register out_data, out_syndrome and out_corrected, and move to DONE.
REQ-020 In DONE, out_valid=1 and the out_* ports SHALL stay stable until out_valid&&out_ready, then return to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid high; peak throughput is one word per 3 cycles.
REQ-022 in_valid while not in IDLE SHALL be ignored; no buffering, no word lost once accepted.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 out_data, out_syndrome and out_corrected SHALL hold their last values in IDLE and CALC.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE with in_ready=1, out_valid=0, out_data=0, out_syndrome=0, out_corrected=0 and err_cnt=0.
REQ-026 Reset asserted mid-operation SHALL discard the pending word, with no partial output.
REQ-027 The first acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With ERR_COUNT_EN defined, err_cnt SHALL increment by 1 on the edge entering DONE with out_corrected=1, saturating at 2^ERR_CNT_W-1.
REQ-029 Without ERR_COUNT_EN, err_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-030 A shared package hamming_pkg SHALL hold:
- the codeword_t (7-bit), data_t (4-bit) and syndrome_t (3-bit) typedefs;
- the FSM state enum;
- the parity/data bit-position constants.
REQ-031 Syndrome computation and the single-bit flip SHALL live in the combinational sub-module hamming_syndrome (in codeword_t, out syndrome_t and corrected codeword_t), instantiated once.

Verification
REQ-032 Valid word with no error: in_word=7'h55 -> out_data=4'b1011, out_syndrome=4'h0, out_corrected=0, out_valid exactly 2 cycles after acceptance.
REQ-033 Single-bit errors on the same word:
- in_word=7'h75 (e5 flipped) -> out_data=4'b1011, out_syndrome=4'h6, out_corrected=1.
- in_word=7'h54 (e0 flipped) -> out_data=4'b1011, out_syndrome=4'h1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with a new word -> in_ready stays 0, outputs stay stable, the new word is only accepted after the handshake.
REQ-035 Reset in CALC: assert rst_n=0 -> out_valid=0 and in_ready=1 immediately, with no result emitted.
REQ-036 Counter (ERR_COUNT_EN, ERR_CNT_W=2): send 5 corrupted words -> err_cnt reads 1,2,3,3,3; without the macro err_cnt stays 0.
